// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit for the EX stage.
// Owns the architectural HI/LO registers. A legal start runs WIDTH
// iterations in RUN, then one FIX cycle applies the signs and writes HI/LO.
// While an operation is pending, busy is high and dependent requests stall.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mfhi,
    input  logic             mflo,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 div_r;
    logic                 neg_res_r;
    logic                 neg_rem_r;
    logic [WIDTH-1:0]     op_r;      // multiplicand (mult) or divisor (div), magnitude
    logic [2*WIDTH-1:0]   prod_r;    // upper: partial product, lower: remaining multiplier bits
    logic [WIDTH:0]       rem_r;     // partial remainder, extra bit exposes the borrow
    logic [WIDTH-1:0]     quo_r;     // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 legal_s;
    logic                 div_op_s;
    logic                 signed_op_s;
    logic                 a_neg_s;
    logic                 b_neg_s;
    logic [WIDTH-1:0]     abs_a_s;
    logic [WIDTH-1:0]     abs_b_s;
    logic [WIDTH:0]       mul_add_s;
    logic [2*WIDTH-1:0]   prod_step_s;
    logic [WIDTH+1:0]     div_shl_s;
    logic [WIDTH+1:0]     div_diff_s;
    logic [WIDTH:0]       rem_step_s;
    logic                 q_bit_s;
    logic [WIDTH-1:0]     quo_step_s;
    logic [2*WIDTH-1:0]   prod_fix_s;
    logic [WIDTH-1:0]     quo_fix_s;
    logic [WIDTH-1:0]     rem_fix_s;

    // Decode the operation select into legality, divide and signedness flags.
    always_comb begin
        legal_s     = 1'b0;
        div_op_s    = 1'b0;
        signed_op_s = 1'b0;
        case (funct)
            FN_MULT: begin
                legal_s     = 1'b1;
                signed_op_s = 1'b1;
            end
            FN_MULTU: begin
                legal_s     = 1'b1;
            end
            FN_DIV: begin
                legal_s     = 1'b1;
                div_op_s    = 1'b1;
                signed_op_s = 1'b1;
            end
            FN_DIVU: begin
                legal_s     = 1'b1;
                div_op_s    = 1'b1;
            end
            default: begin
                legal_s     = 1'b0;
                div_op_s    = 1'b0;
                signed_op_s = 1'b0;
            end
        endcase
    end

    // Take operand magnitudes so the iteration datapath is purely unsigned.
    always_comb begin
        a_neg_s = signed_op_s & srca[WIDTH-1];
        b_neg_s = signed_op_s & srcb[WIDTH-1];
        if (a_neg_s) begin
            abs_a_s = -srca;
        end else begin
            abs_a_s = srca;
        end
        if (b_neg_s) begin
            abs_b_s = -srcb;
        end else begin
            abs_b_s = srcb;
        end
    end

    // One shift-add multiply step and one restoring divide step.
    always_comb begin
        if (prod_r[0]) begin
            mul_add_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, op_r};
        end else begin
            mul_add_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
        end
        prod_step_s = {mul_add_s, prod_r[WIDTH-1:1]};

        div_shl_s  = {rem_r, quo_r[WIDTH-1]};
        div_diff_s = div_shl_s - {2'b00, op_r};
        if (div_diff_s[WIDTH+1]) begin
            rem_step_s = div_shl_s[WIDTH:0];
            q_bit_s    = 1'b0;
        end else begin
            rem_step_s = div_diff_s[WIDTH:0];
            q_bit_s    = 1'b1;
        end
        quo_step_s = {quo_r[WIDTH-2:0], q_bit_s};
    end

    // Sign fixup of the unsigned results; a zero divisor forces an all-ones quotient.
    always_comb begin
        if (neg_res_r) begin
            prod_fix_s = -prod_r;
        end else begin
            prod_fix_s = prod_r;
        end
        if (op_r == {WIDTH{1'b0}}) begin
            quo_fix_s = {WIDTH{1'b1}};
        end else if (neg_res_r) begin
            quo_fix_s = -quo_r;
        end else begin
            quo_fix_s = quo_r;
        end
        if (neg_rem_r) begin
            rem_fix_s = -rem_r[WIDTH-1:0];
        end else begin
            rem_fix_s = rem_r[WIDTH-1:0];
        end
    end

    // Read port and hazard stall toward the pipeline; mfhi has priority.
    always_comb begin
        if (mfhi) begin
            rdata = hi_r;
        end else begin
            rdata = lo_r;
        end
        stall = busy_r & (start | mfhi | mflo);
    end

    // Control FSM with datapath registers and HI/LO/busy/done outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            div_r     <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            op_r      <= {WIDTH{1'b0}};
            prod_r    <= {(2*WIDTH){1'b0}};
            rem_r     <= {(WIDTH+1){1'b0}};
            quo_r     <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start && legal_s) begin
                        state_r   <= RUN;
                        busy_r    <= 1'b1;
                        cnt_r     <= {CNT_W{1'b0}};
                        div_r     <= div_op_s;
                        neg_res_r <= a_neg_s ^ b_neg_s;
                        neg_rem_r <= a_neg_s;
                        if (div_op_s) begin
                            op_r <= abs_b_s;
                        end else begin
                            op_r <= abs_a_s;
                        end
                        prod_r <= {{WIDTH{1'b0}}, abs_b_s};
                        quo_r  <= abs_a_s;
                        rem_r  <= {(WIDTH+1){1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (div_r) begin
                        rem_r <= rem_step_s;
                        quo_r <= quo_step_s;
                    end else begin
                        prod_r <= prod_step_s;
                    end
                    if (cnt_r == LAST_ITER) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FIX: begin
                    if (div_r) begin
                        hi_r <= rem_fix_s;
                        lo_r <= quo_fix_s;
                    end else begin
                        hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix_s[WIDTH-1:0];
                    end
                    cnt_r   <= {CNT_W{1'b0}};
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide execution unit for the pipelined MIPS core.
- Sits in EX. It acts on the decoder's muldiv, mfhi and mflo controls and owns the architectural HI/LO registers.
- Executes mult, multu, div and divu iteratively (radix-2).
- Supplies HI/LO data to mfhi/mflo, and raises a stall to the hazard unit while a result is pending.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  decoder muldiv qualified in EX; requests a new operation.
- funct  in  6  operation select: 011000 mult, 011001 multu, 011010 div, 011011 divu.
- srca  in  WIDTH  rs value (multiplicand / dividend).
- srcb  in  WIDTH  rt value (multiplier / divisor).
- mfhi  in  1  EX-stage mfhi request.
- mflo  in  1  EX-stage mflo request.
- rdata  out  WIDTH  mfhi ? hi : lo; combinational.
- hi  out  WIDTH  architectural HI register.
- lo  out  WIDTH  architectural LO register.
- busy  out  1  operation in progress.
- stall  out  1  busy & (start | mfhi | mflo); combinational, to the hazard unit.
- done  out  1  one-cycle pulse, asserted the cycle after HI/LO are updated.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0.
  - Any in-flight operation is discarded.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 with a legal funct at edge E0: latch op, sign flags, |srca|, |srcb| (abs only for signed ops), clear the accumulator, cnt=0, go to RUN.
  - Illegal funct with start: ignored; stay in IDLE.
  - start=0: hold.
- RUN: one iteration per edge; cnt increments; after the WIDTH-th iteration (edge E32 at default width) go to FIX.
- Multiply iteration: shift-add on a 2*WIDTH-bit unsigned product; one multiplier bit per cycle, LSB first.
- Divide iteration: restoring division, one quotient bit per cycle, MSB first. The remainder register is WIDTH+1 bits so the subtract borrow is visible.
- FIX (edge E33), then back to IDLE:
  - Apply sign fixup: product negated if the operand signs differ (signed mult only); quotient negated if signs differ; remainder takes the dividend's sign (signed div only).
  - Write hi/lo.
- Result mapping:
  - mult/multu: hi=product[2W-1:W], lo=product[W-1:0].
  - div/divu: lo=quotient, hi=remainder.
- Divide by zero: no trap, full 33-cycle latency; lo=all ones, hi=srca as originally presented.
- Signed overflow (0x80000000 div 0xFFFFFFFF): lo=0x80000000, hi=0, with no special path (it falls out of the abs/unsigned datapath).
- Timing:
  - busy=1 from the cycle after E0 through the cycle ending at E33, i.e. 33 cycles.
  - done=1 for exactly the cycle after E33.
  - hi/lo are unchanged from E0 until E33.
- start while busy: not accepted. stall holds the pipeline, so the same instruction re-presents start and is accepted on the first IDLE cycle.
- start asserted in the cycle where done=1 (state already IDLE): accepted normally; no dead cycle.
- mfhi/mflo while busy: stall=1 and rdata is don't-care. Once busy=0, rdata returns the new result in the same cycle.
- mfhi and mflo both asserted: mfhi wins (rdata=hi).

Test Plan:
- Reset release, then mflo=1 → rdata=0, busy=0, stall=0. Assert reset_n=0 in the middle of a divide → hi=lo=0 immediately, busy=0, no done pulse.
- mult, srca=0xFFFFFFFE (-2), srcb=0x00000003 → 33 busy cycles, done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFFA. Repeat as multu → hi=0x00000002, lo=0xFFFFFFFA.
- div, srca=0xFFFFFFF9 (-7), srcb=0x00000002 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu, srca=100, srcb=7 → lo=14, hi=2.
- Divide by zero (divu, srca=0x12345678, srcb=0) → lo=0xFFFFFFFF, hi=0x12345678 after 33 cycles. div 0x80000000 by 0xFFFFFFFF → lo=0x80000000, hi=0.
- Hazards:
  - Issue mult, then hold mfhi=1 → stall=1 every busy cycle; stall drops the cycle busy falls, with rdata=the new hi.
  - A second start during busy → ignored until IDLE, then accepted.
  - Start in the done cycle → busy reasserts next cycle.
- Back-to-back: mult 3*5, then immediately divu 100/7 → done pulses 34 cycles apart; final hi=2, lo=14.
